// File: rtl/ahb_bridge_arbiter.sv
// Two-master AHB arbiter in front of a single bridge slave port: muxes the
// granted master onto the bridge, tracks burst beats and round-robin handover.
module ahb_bridge_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  hclk,
   input  logic                  resetn,
   input  logic [1:0]            hbusreq,
   input  logic [1:0]            htrans_m0,
   input  logic [1:0]            htrans_m1,
   input  logic [31:0]           haddr_m0,
   input  logic [31:0]           haddr_m1,
   input  logic                  hwrite_m0,
   input  logic                  hwrite_m1,
   input  logic [2:0]            hburst_m0,
   input  logic [2:0]            hburst_m1,
   input  logic [2:0]            hsize_m0,
   input  logic [2:0]            hsize_m1,
   input  logic [DATA_WIDTH-1:0] hwdata_m0,
   input  logic [DATA_WIDTH-1:0] hwdata_m1,
   input  logic                  hready_i,
   input  logic                  hresp_i,
   output logic [1:0]            hgrant,
   output logic                  hmaster,
   output logic                  hmaster_d,
   output logic                  hsel_o,
   output logic [1:0]            htrans_o,
   output logic [31:0]           haddr_o,
   output logic                  hwrite_o,
   output logic [2:0]            hburst_o,
   output logic [2:0]            hsize_o,
   output logic [DATA_WIDTH-1:0] hwdata_o
);

   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   localparam logic [2:0] BURST_INCR   = 3'b001;
   localparam logic [2:0] BURST_WRAP4  = 3'b010;
   localparam logic [2:0] BURST_INCR4  = 3'b011;
   localparam logic [2:0] BURST_WRAP8  = 3'b100;
   localparam logic [2:0] BURST_INCR8  = 3'b101;
   localparam logic [2:0] BURST_WRAP16 = 3'b110;
   localparam logic [2:0] BURST_INCR16 = 3'b111;

   logic [4:0] beat_cnt;
   logic [4:0] cnt_nxt;
   logic       locked;
   logic       lock_nxt;
   logic       error_done;
   logic       nonseq_acc;
   logic       seq_acc;
   logic       owner_req;
   logic       other_req;
   logic       releasable;
   logic       handover;

   always_comb begin
      if (hmaster) begin
         htrans_o = htrans_m1;
         haddr_o  = haddr_m1;
         hwrite_o = hwrite_m1;
         hburst_o = hburst_m1;
         hsize_o  = hsize_m1;
      end else begin
         htrans_o = htrans_m0;
         haddr_o  = haddr_m0;
         hwrite_o = hwrite_m0;
         hburst_o = hburst_m0;
         hsize_o  = hsize_m0;
      end
   end

   assign hwdata_o = hmaster_d ? hwdata_m1 : hwdata_m0;
   assign hsel_o   = htrans_o[1];
   assign hgrant   = hmaster ? 2'b10 : 2'b01;

   assign error_done = hready_i & hresp_i;
   assign nonseq_acc = hready_i & (htrans_o == TRANS_NONSEQ);
   assign seq_acc    = hready_i & (htrans_o == TRANS_SEQ);
   assign owner_req  = hmaster ? hbusreq[1] : hbusreq[0];
   assign other_req  = hmaster ? hbusreq[0] : hbusreq[1];

   always_comb begin
      cnt_nxt  = beat_cnt;
      lock_nxt = locked;
      if (error_done) begin
         cnt_nxt  = '0;
         lock_nxt = 1'b0;
      end else if (nonseq_acc) begin
         lock_nxt = 1'b0;
         case (hburst_o)
            BURST_INCR:                 begin cnt_nxt = 5'd0; lock_nxt = 1'b1; end
            BURST_WRAP4,  BURST_INCR4:  cnt_nxt = 5'd3;
            BURST_WRAP8,  BURST_INCR8:  cnt_nxt = 5'd7;
            BURST_WRAP16, BURST_INCR16: cnt_nxt = 5'd15;
            default:                    cnt_nxt = 5'd0;
         endcase
      end else if (seq_acc && beat_cnt != '0) begin
         cnt_nxt = beat_cnt - 5'd1;
      end
      // Release test uses the post-update count and lock, so the final beat hands over directly.
      releasable = error_done |
                   (hready_i & (cnt_nxt == '0) & (~lock_nxt | ~owner_req));
      handover   = releasable & other_req;
      if (handover || (hready_i && !owner_req))
         lock_nxt = 1'b0;
   end

   always_ff @(posedge hclk or negedge resetn) begin
      if (!resetn) begin
         hmaster   <= 1'b0;
         hmaster_d <= 1'b0;
         beat_cnt  <= '0;
         locked    <= 1'b0;
      end else begin
         beat_cnt <= cnt_nxt;
         locked   <= lock_nxt;
         if (handover)
            hmaster <= ~hmaster;
         if (hready_i)
            hmaster_d <= hmaster;
      end
   end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter: per-cycle stimulus pushes the
// expected owner state to a scoreboard, popped and compared after each edge.
module tb_ahb_bridge_arbiter;

   localparam int DW = 32;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR   = 3'b001;
   localparam logic [2:0] INCR4  = 3'b011;
   localparam logic [2:0] WRAP8  = 3'b100;
   localparam logic [2:0] INCR16 = 3'b111;

   localparam logic [31:0] ADDR0 = 32'h1000_0040;
   localparam logic [31:0] ADDR1 = 32'h2000_0080;

   logic          hclk = 1'b0;
   logic          resetn;
   logic [1:0]    hbusreq;
   logic [1:0]    htrans_m0, htrans_m1;
   logic [31:0]   haddr_m0, haddr_m1;
   logic          hwrite_m0, hwrite_m1;
   logic [2:0]    hburst_m0, hburst_m1;
   logic [2:0]    hsize_m0, hsize_m1;
   logic [DW-1:0] hwdata_m0, hwdata_m1;
   logic          hready_i, hresp_i;
   logic [1:0]    hgrant;
   logic          hmaster, hmaster_d;
   logic          hsel_o;
   logic [1:0]    htrans_o;
   logic [31:0]   haddr_o;
   logic          hwrite_o;
   logic [2:0]    hburst_o, hsize_o;
   logic [DW-1:0] hwdata_o;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [1:0]  sb_q[$];
   logic        cur_hm;
   logic        cur_hmd;

   ahb_bridge_arbiter #(.DATA_WIDTH(DW)) dut (
      .hclk      (hclk),
      .resetn    (resetn),
      .hbusreq   (hbusreq),
      .htrans_m0 (htrans_m0),
      .htrans_m1 (htrans_m1),
      .haddr_m0  (haddr_m0),
      .haddr_m1  (haddr_m1),
      .hwrite_m0 (hwrite_m0),
      .hwrite_m1 (hwrite_m1),
      .hburst_m0 (hburst_m0),
      .hburst_m1 (hburst_m1),
      .hsize_m0  (hsize_m0),
      .hsize_m1  (hsize_m1),
      .hwdata_m0 (hwdata_m0),
      .hwdata_m1 (hwdata_m1),
      .hready_i  (hready_i),
      .hresp_i   (hresp_i),
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .hmaster_d (hmaster_d),
      .hsel_o    (hsel_o),
      .htrans_o  (htrans_o),
      .haddr_o   (haddr_o),
      .hwrite_o  (hwrite_o),
      .hburst_o  (hburst_o),
      .hsize_o   (hsize_o),
      .hwdata_o  (hwdata_o)
   );

   always #5 hclk = ~hclk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One bus cycle: drive inputs, check the combinational muxes against the
   // current expected owners, then compare post-edge owners from the scoreboard.
   task automatic step(input string tag,
                       input logic [1:0] t0, input logic [2:0] b0,
                       input logic [1:0] t1, input logic [2:0] b1,
                       input logic [1:0] req, input logic rdy, input logic rsp,
                       input logic exp_hm, input logic exp_hmd);
      logic [1:0]    sel_trans;
      logic [1:0]    e;
      logic [DW-1:0] exp_wdata;
      htrans_m0 = t0;
      hburst_m0 = b0;
      htrans_m1 = t1;
      hburst_m1 = b1;
      hbusreq   = req;
      hready_i  = rdy;
      hresp_i   = rsp;
      hwdata_m0 = $urandom;
      hwdata_m1 = $urandom;
      #1;
      sel_trans = cur_hm ? t1 : t0;
      exp_wdata = cur_hmd ? hwdata_m1 : hwdata_m0;
      check_eq({tag, "/hsel"},   {63'd0, hsel_o},   {63'd0, sel_trans[1]});
      check_eq({tag, "/haddr"},  {32'd0, haddr_o},  {32'd0, (cur_hm ? ADDR1 : ADDR0)});
      check_eq({tag, "/hburst"}, {61'd0, hburst_o}, {61'd0, (cur_hm ? b1 : b0)});
      check_eq({tag, "/hwrite"}, {63'd0, hwrite_o}, {63'd0, ~cur_hm});
      check_eq({tag, "/hwdata"}, {32'd0, hwdata_o}, {32'd0, exp_wdata});
      sb_q.push_back({exp_hm, exp_hmd});
      @(posedge hclk);
      #1;
      if (sb_q.size() == 0) begin
         check_eq({tag, "/scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         check_eq({tag, "/hmaster"},   {63'd0, hmaster},   {63'd0, e[1]});
         check_eq({tag, "/hmaster_d"}, {63'd0, hmaster_d}, {63'd0, e[0]});
         check_eq({tag, "/hgrant"},    {62'd0, hgrant},    {62'd0, (e[1] ? 2'b10 : 2'b01)});
         cur_hm  = e[1];
         cur_hmd = e[0];
      end
   endtask

   initial begin
      resetn    = 1'b0;
      hbusreq   = 2'b00;
      htrans_m0 = IDLE;
      htrans_m1 = NONSEQ;
      haddr_m0  = ADDR0;
      haddr_m1  = ADDR1;
      hwrite_m0 = 1'b1;
      hwrite_m1 = 1'b0;
      hburst_m0 = SINGLE;
      hburst_m1 = SINGLE;
      hsize_m0  = 3'b010;
      hsize_m1  = 3'b001;
      hwdata_m0 = 32'hA5A5_0000;
      hwdata_m1 = 32'h5A5A_1111;
      hready_i  = 1'b1;
      hresp_i   = 1'b0;
      cur_hm    = 1'b0;
      cur_hmd   = 1'b0;

      // In reset: master 0 owns everything
      #3;
      check_eq("rst/hgrant",    {62'd0, hgrant},    64'd1);
      check_eq("rst/hmaster",   {63'd0, hmaster},   64'd0);
      check_eq("rst/hmaster_d", {63'd0, hmaster_d}, 64'd0);
      check_eq("rst/haddr",     {32'd0, haddr_o},   {32'd0, ADDR0});
      check_eq("rst/hwdata",    {32'd0, hwdata_o},  {32'd0, 32'hA5A5_0000});
      check_eq("rst/hsel",      {63'd0, hsel_o},    64'd0);
      #2;
      resetn = 1'b1;

      // Idle after reset, nobody requesting
      for (int i = 0; i < 10; i++)
         step("idle", IDLE, SINGLE, IDLE, SINGLE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

      // INCR4 from M0, M1 requesting from the NONSEQ cycle
      step("incr4_ns", NONSEQ, INCR4, IDLE, SINGLE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      step("incr4_s1", SEQ,    INCR4, IDLE, SINGLE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      step("incr4_s2", SEQ,    INCR4, IDLE, SINGLE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      step("incr4_s3", SEQ,    INCR4, IDLE, SINGLE, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
      step("incr4_m1", IDLE,   SINGLE, IDLE, SINGLE, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);

      // Wait states on an M0 SINGLE with M1 requesting
      step("ws_back", IDLE, SINGLE, IDLE, SINGLE, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++)
         step("ws_wait", NONSEQ, SINGLE, IDLE, SINGLE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      step("ws_acc",  NONSEQ, SINGLE, IDLE, SINGLE, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
      step("ws_d",    IDLE,   SINGLE, IDLE, SINGLE, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);

      // Round-robin with both masters issuing SINGLEs
      for (int i = 0; i < 6; i++)
         step("rr", NONSEQ, SINGLE, NONSEQ, SINGLE, 2'b11, 1'b1, 1'b0,
              (i % 2 == 1), (i % 2 == 0));

      // Undefined-length INCR from M1, M0 requesting
      step("incr_ns", IDLE, SINGLE, NONSEQ, INCR, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++)
         step("incr_seq", IDLE, SINGLE, SEQ, INCR, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      step("incr_drop_wait", IDLE, SINGLE, SEQ, INCR, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
      step("incr_drop_rdy",  IDLE, SINGLE, SEQ, INCR, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
      step("incr_after",     IDLE, SINGLE, IDLE, SINGLE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

      // ERROR on beat 2 of an M0 WRAP8, M1 requesting
      step("err_ns",   NONSEQ, WRAP8, IDLE, SINGLE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      step("err_s1",   SEQ,    WRAP8, IDLE, SINGLE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      step("err_resp1", SEQ,   WRAP8, IDLE, SINGLE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      step("err_resp2", IDLE,  WRAP8, IDLE, SINGLE, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      step("err_after", IDLE, SINGLE, IDLE, SINGLE, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);

      // Reset asserted in the middle of an M1 INCR16
      step("rb_ns", IDLE, SINGLE, NONSEQ, INCR16, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      step("rb_s1", IDLE, SINGLE, SEQ,    INCR16, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check_eq("midrst/hgrant",    {62'd0, hgrant},        64'd1);
      check_eq("midrst/hmaster",   {63'd0, hmaster},       64'd0);
      check_eq("midrst/hmaster_d", {63'd0, hmaster_d},     64'd0);
      check_eq("midrst/beat_cnt",  {59'd0, dut.beat_cnt},  64'd0);
      check_eq("midrst/haddr",     {32'd0, haddr_o},       {32'd0, ADDR0});
      cur_hm  = 1'b0;
      cur_hmd = 1'b0;
      #2;
      resetn = 1'b1;
      step("postrst_m1", IDLE, SINGLE, IDLE, SINGLE, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
      step("postrst_hold", IDLE, SINGLE, IDLE, SINGLE, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
